// File: rtl/register_file.sv
// register_file
//   Sixteen-entry general-purpose register bank with one synchronous write
//   port and two registered read ports (A and B). A read and a write to the
//   same index at the same edge return the incoming write data, so a value
//   written in cycle N can be consumed in cycle N without a stall.
//
// Ports
//   Clock       in   sole clock, rising-edge
//   Reset       in   synchronous active-high clear of all state
//   WrEnable    in   write strobe
//   WrAddr      in   write index
//   WrData      in   write data
//   RdEnableA   in   capture strobe for port A
//   RdAddrA     in   port A read index
//   RdEnableB   in   capture strobe for port B
//   RdAddrB     in   port B read index
//   ReadDataA   out  registered port A data (holds when not enabled)
//   ReadDataB   out  registered port B data (holds when not enabled)
//   ReadValidA  out  one-cycle pulse after an accepted port A read
//   ReadValidB  out  one-cycle pulse after an accepted port B read
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WrEnable,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic [DATA_WIDTH-1:0] WrData,
  input  logic                  RdEnableA,
  input  logic [ADDR_WIDTH-1:0] RdAddrA,
  input  logic                  RdEnableB,
  input  logic [ADDR_WIDTH-1:0] RdAddrB,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  output logic [DATA_WIDTH-1:0] ReadDataB,
  output logic                  ReadValidA,
  output logic                  ReadValidB
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Register storage. Every entry is cleared by reset, so this maps to flops
  // rather than block RAM; index 0 is an ordinary writable register.
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  // One-hot write select, one bit per entry.
  logic [DEPTH-1:0] wr_sel;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = WrEnable && (WrAddr == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (Reset) begin
        regs_q[i] <= '0;
      end else if (wr_sel[i]) begin
        regs_q[i] <= WrData;
      end
    end
  end

  // Forwarding: a same-edge write to the read index wins over the stored
  // value, so the old array contents never leak through on a collision.
  logic [DATA_WIDTH-1:0] fwd_a_d;
  logic [DATA_WIDTH-1:0] fwd_b_d;

  always_comb begin
    fwd_a_d = regs_q[RdAddrA];
    fwd_b_d = regs_q[RdAddrB];
    if (WrEnable && (WrAddr == RdAddrA)) begin
      fwd_a_d = WrData;
    end
    if (WrEnable && (WrAddr == RdAddrB)) begin
      fwd_b_d = WrData;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_a_q;
  logic [DATA_WIDTH-1:0] rd_data_b_q;
  logic                  rd_valid_a_q;
  logic                  rd_valid_b_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_valid_a_q <= RdEnableA;
      rd_valid_b_q <= RdEnableB;
      if (RdEnableA) begin
        rd_data_a_q <= fwd_a_d;
      end
      if (RdEnableB) begin
        rd_data_b_q <= fwd_b_d;
      end
    end
  end

  assign ReadDataA  = rd_data_a_q;
  assign ReadDataB  = rd_data_b_q;
  assign ReadValidA = rd_valid_a_q;
  assign ReadValidB = rd_valid_b_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file: a table of directed cycles with
//   hand-computed expected outputs, a write/read-all sweep, and a random run
//   compared against a cycle-level reference model.
module tb_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WrEnable;
  logic [3:0]  WrAddr;
  logic [15:0] WrData;
  logic        RdEnableA;
  logic [3:0]  RdAddrA;
  logic        RdEnableB;
  logic [3:0]  RdAddrB;
  logic [15:0] ReadDataA;
  logic [15:0] ReadDataB;
  logic        ReadValidA;
  logic        ReadValidB;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WrEnable   (WrEnable),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .RdEnableA  (RdEnableA),
    .RdAddrA    (RdAddrA),
    .RdEnableB  (RdEnableB),
    .RdAddrB    (RdAddrB),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .ReadValidA (ReadValidA),
    .ReadValidB (ReadValidB)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rea;
    logic [3:0]  ra;
    logic        reb;
    logic [3:0]  rb;
    logic [15:0] exp_da;
    logic        exp_va;
    logic [15:0] exp_db;
    logic        exp_vb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic we, logic [3:0] wa,
                              logic [15:0] wd, logic rea, logic [3:0] ra,
                              logic reb, logic [3:0] rb, logic [15:0] exp_da,
                              logic exp_va, logic [15:0] exp_db, logic exp_vb);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.rea = rea; v.ra = ra; v.reb = reb; v.rb = rb;
    v.exp_da = exp_da; v.exp_va = exp_va; v.exp_db = exp_db; v.exp_vb = exp_vb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h want 0x%04h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle past the edge.
  task automatic cycle(input logic rst, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic rea, input logic [3:0] ra,
                       input logic reb, input logic [3:0] rb);
    Reset = rst; WrEnable = we; WrAddr = wa; WrData = wd;
    RdEnableA = rea; RdAddrA = ra; RdEnableB = reb; RdAddrB = rb;
    @(posedge Clock);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [15:0] da, input logic va,
                               input logic [15:0] db, input logic vb);
    chk({name, ".da"}, ReadDataA, da);
    chk({name, ".va"}, {15'd0, ReadValidA}, {15'd0, va});
    chk({name, ".db"}, ReadDataB, db);
    chk({name, ".vb"}, {15'd0, ReadValidB}, {15'd0, vb});
  endtask

  // Reference model state for the random run.
  logic [15:0] m_regs [16];
  logic [15:0] m_da, m_db;
  logic        m_va, m_vb;

  initial begin
    Reset = 1'b1; WrEnable = 1'b0; WrAddr = '0; WrData = '0;
    RdEnableA = 1'b0; RdAddrA = '0; RdEnableB = 1'b0; RdAddrB = '0;

    //                 name        rst we wa  wd        rea ra  reb rb  da        va  db        vb
    vecs.push_back(mk("reset0",    1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk("wr_r5",     0, 1, 5, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk("rst_pulse", 1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk("rd_r5",     0, 0, 0, 16'h0000, 1, 5, 0, 0, 16'h0000, 1, 16'h0000, 0));
    vecs.push_back(mk("wr_r3a",    0, 1, 3, 16'h1111, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk("fwd_r3",    0, 1, 3, 16'h2222, 1, 3, 1, 3, 16'h2222, 1, 16'h2222, 1));
    vecs.push_back(mk("rd_r3",     0, 0, 0, 16'h0000, 1, 3, 0, 0, 16'h2222, 1, 16'h2222, 0));
    vecs.push_back(mk("wr_r7",     0, 1, 7, 16'h00AA, 0, 0, 0, 0, 16'h2222, 0, 16'h2222, 0));
    vecs.push_back(mk("rd_r7",     0, 0, 0, 16'h0000, 1, 7, 0, 0, 16'h00AA, 1, 16'h2222, 0));
    vecs.push_back(mk("hold1",     0, 1, 7, 16'h5555, 0, 7, 0, 0, 16'h00AA, 0, 16'h2222, 0));
    vecs.push_back(mk("hold2",     0, 1, 7, 16'h5555, 0, 7, 0, 0, 16'h00AA, 0, 16'h2222, 0));
    vecs.push_back(mk("hold3",     0, 1, 7, 16'h5555, 0, 7, 0, 0, 16'h00AA, 0, 16'h2222, 0));
    vecs.push_back(mk("rd_r7b",    0, 0, 0, 16'h0000, 1, 7, 0, 0, 16'h5555, 1, 16'h2222, 0));
    vecs.push_back(mk("wr_r2",     0, 1, 2, 16'h1234, 0, 0, 0, 0, 16'h5555, 0, 16'h2222, 0));
    vecs.push_back(mk("rst_prio",  1, 1, 2, 16'hFFFF, 1, 2, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk("rd_r2",     0, 0, 0, 16'h0000, 1, 2, 1, 2, 16'h0000, 1, 16'h0000, 1));
    vecs.push_back(mk("wr_r0",     0, 1, 0, 16'hABCD, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk("rd_r0b",    0, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 16'hABCD, 1));

    @(negedge Clock);
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].rea, vecs[i].ra, vecs[i].reb, vecs[i].rb);
      $display("vec %0d %s: da=0x%04h va=%0b db=0x%04h vb=%0b", i, vecs[i].name,
               ReadDataA, ReadValidA, ReadDataB, ReadValidB);
      check_outputs(vecs[i].name, vecs[i].exp_da, vecs[i].exp_va,
                    vecs[i].exp_db, vecs[i].exp_vb);
    end

    // Write/read-all sweep: A walks up, B walks down.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 4'(i), 16'h1000 + 16'(i), 0, 0, 0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 0, 1, 4'(i), 1, 4'(15 - i));
      $display("sweep %0d: da=0x%04h db=0x%04h", i, ReadDataA, ReadDataB);
      check_outputs("sweep", 16'h1000 + 16'(i), 1'b1, 16'h1000 + 16'(15 - i), 1'b1);
    end

    // Random run against the reference model.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic        rst, we, rea, reb;
      logic [3:0]  wa, ra, rb;
      logic [15:0] wd, fa, fb;
      rst = ($urandom_range(0, 99) == 0);
      we  = 1'($urandom_range(0, 1));
      rea = 1'($urandom_range(0, 1));
      reb = 1'($urandom_range(0, 1));
      // Narrow address range on some cycles to provoke collisions.
      wa  = 4'($urandom_range(0, 15));
      ra  = (n % 3 == 0) ? wa : 4'($urandom_range(0, 15));
      rb  = (n % 5 == 0) ? ra : 4'($urandom_range(0, 15));
      wd  = 16'($urandom);
      if (rst) begin
        for (int k = 0; k < 16; k++) m_regs[k] = '0;
        m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0;
      end else begin
        fa = (we && wa == ra) ? wd : m_regs[ra];
        fb = (we && wa == rb) ? wd : m_regs[rb];
        if (rea) m_da = fa;
        if (reb) m_db = fb;
        m_va = rea;
        m_vb = reb;
        if (we) m_regs[wa] = wd;
      end
      cycle(rst, we, wa, wd, rea, ra, reb, rb);
      if (n % 1000 == 0) begin
        $display("rand %0d: da=0x%04h va=%0b db=0x%04h vb=%0b", n,
                 ReadDataA, ReadValidA, ReadDataB, ReadValidB);
      end
      check_outputs("rand", m_da, m_va, m_db, m_vb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
